timer_irq_source: RTL and testbench
===================================

Name: timer_irq_source

Overview:
- Memory-mapped countdown timer: the device end of the hardware-interrupt interface that feeds the coprocessor's HWInt inputs.
- The CPU programs it through three word registers (CTRL, PRESET, COUNT) over the bridge bus.
- It raises IRQ when the count expires, either one-shot (level, held until serviced) or periodic (one-cycle pulse per period).
- IRQ connects to one HWInt bit (HWInt[2] for timer 0).

Parameters:
- WIDTH, 32, data/counter width.
- CTRL_MASK, 32'h0000_000F, writable CTRL bits; all other CTRL bits read 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; all state clears immediately on assertion.
- Addr  input  2  word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- We  input  1  write strobe; DIn commits at the rising edge.
- DIn  input  WIDTH  write data.
- DOut  output  WIDTH  combinational read of the register selected by Addr.
- IRQ  output  1  interrupt request to HWInt.

Behaviour:
- CTRL fields: [0] En, [2:1] Mode (0=one-shot, 1=periodic, 2/3 behave as 0), [3] IM (IRQ enable). Other bits are 0.
- Reset values: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0. DOut then reads 0 at every address.
- IRQ = IM & irq_flag (combinational).
- Register reads: CTRL={28'b0,IM,Mode,En}; PRESET; COUNT; Addr=3 reads 0.
- Register writes: COUNT and Addr=3 are ignored. A PRESET write during counting takes effect only at the next LOAD.
- Any CTRL write clears irq_flag.
- FSM transitions:
  - IDLE: En=1 -> LOAD; otherwise stay; COUNT holds.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: En=0 -> IDLE (COUNT frozen). Else if COUNT<=1: COUNT<=0, irq_flag<=1 -> INT. Else COUNT<=COUNT-1.
  - INT, Mode=1: irq_flag<=0 -> LOAD (auto-reload).
  - INT, other modes: En<=0 -> IDLE; irq_flag stays 1 until a CTRL write or reset.
  - INT with En already cleared by the bus: -> IDLE. Mode 1 clears irq_flag; other modes keep it.
- Latency: the write setting En commits at edge E.
  - LOAD at E+1; CNT with COUNT=N at E+2; INT (irq_flag=1) at E+N+2 for N>=1.
  - PRESET=0 behaves exactly as PRESET=1.
  - Periodic mode: INT recurs every N+2 cycles; IRQ is high for exactly 1 cycle per period.
- Simultaneous events:
  - A bus CTRL write and an FSM En-clear (INT, one-shot) in the same cycle: the bus write wins for CTRL.
  - A CTRL write and irq_flag set in the same cycle: set wins, so no interrupt is lost.
- Disable then re-enable: always reloads from PRESET; there is no resume from the frozen COUNT.
- Reset asserted mid-count: returns immediately to reset values. Counting restarts only after software sets En again.
- Arithmetic: unsigned WIDTH-bit down-count; never wraps below 0.

Decomposition:
- Shared package: register offsets (CTRL/PRESET/COUNT), FSM state encodings (IDLE, LOAD, CNT, INT), mode codes, CTRL bit positions.
- No sub-module; the counter and FSM stay in one module.
- Top-level bridge instantiates one timer per HWInt line.

Test Plan:
- Reset then read all 4 addresses -> DOut=0, IRQ=0. Assert reset mid-count (COUNT=5) -> COUNT=0 and IRQ=0 immediately; no IRQ after release.
- One-shot: PRESET=3, CTRL=0x9 at edge E -> COUNT reads 3,2,1,0 at E+2..E+5. IRQ rises at E+5 and holds; CTRL reads 0x8. Write CTRL=0x8 -> IRQ drops next cycle.
- Periodic: PRESET=2, CTRL=0xB -> IRQ 1-cycle pulses at E+4, E+8, E+12.
- Masking: PRESET=1, CTRL=0x1 (IM=0) -> irq_flag set, IRQ stays 0. Write CTRL=0x8 -> flag cleared, IRQ stays 0.
- Disable mid-count: PRESET=10, enable, clear En at COUNT=6 -> COUNT holds 6, no IRQ. Re-enable -> COUNT reloads 10.
- PRESET=0 and Addr=3/COUNT writes: enable -> IRQ at E+3. Writes to COUNT or Addr=3 leave all registers unchanged.

Source files
------------

// File: rtl/timer_irq_source_pkg.sv
// Shared definitions for the HWInt countdown timer:
// register map, FSM encodings, mode codes and CTRL field positions.
package timer_irq_source_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

endpackage

// File: rtl/timer_irq_source.sv
// Memory-mapped countdown timer driving one HWInt line.
// One-shot mode holds IRQ until a CTRL write; periodic mode pulses once per period.
module timer_irq_source
    import timer_irq_source_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] CTRL_MASK = WIDTH'(32'h0000_000F)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Addr,
    input  logic             We,
    input  logic [WIDTH-1:0] DIn,
    output logic [WIDTH-1:0] DOut,
    output logic             IRQ
);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] ctrl_q;
    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] count_q;
    logic             flag_q;

    logic [WIDTH-1:0] ctrl_nx;
    logic [WIDTH-1:0] count_nx;
    logic             flag_nx;

    logic       en;
    logic       im;
    logic [1:0] mode;
    logic       periodic;
    logic       at_end;
    logic       expire;
    logic       ctrl_wr;
    logic       preset_wr;

    assign en        = ctrl_q[CTRL_EN];
    assign im        = ctrl_q[CTRL_IM];
    assign mode      = ctrl_q[CTRL_MODE_LO +: 2];
    assign periodic  = (mode == MODE_PERIODIC);
    assign at_end    = (count_q <= WIDTH'(1));
    assign expire    = (state == ST_CNT) && en && at_end;
    assign ctrl_wr   = We && (Addr == ADDR_CTRL);
    assign preset_wr = We && (Addr == ADDR_PRESET);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (en) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_CNT;
            ST_CNT: begin
                if (!en)        state_nx = ST_IDLE;
                else if (at_end) state_nx = ST_INT;
            end
            ST_INT: state_nx = (periodic && en) ? ST_LOAD : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Bus CTRL write overrides the FSM En-clear; a same-cycle expiry
    // still sets the flag so no interrupt is lost.
    always_comb begin
        ctrl_nx  = ctrl_q;
        count_nx = count_q;
        flag_nx  = flag_q;
        case (state)
            ST_LOAD: count_nx = preset_q;
            ST_CNT: begin
                if (en) count_nx = at_end ? '0 : count_q - WIDTH'(1);
            end
            ST_INT: begin
                if (periodic) flag_nx = 1'b0;
                else          ctrl_nx[CTRL_EN] = 1'b0;
            end
            default: ;
        endcase
        if (ctrl_wr) begin
            ctrl_nx = DIn & CTRL_MASK;
            flag_nx = 1'b0;
        end
        if (expire) flag_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_nx;
            count_q <= count_nx;
            flag_q  <= flag_nx;
            if (preset_wr) preset_q <= DIn;
        end
    end

    always_comb begin
        case (Addr)
            ADDR_CTRL:   DOut = ctrl_q;
            ADDR_PRESET: DOut = preset_q;
            ADDR_COUNT:  DOut = count_q;
            default:     DOut = '0;
        endcase
    end

    assign IRQ = im & flag_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// Scoreboard bench for timer_irq_source: directed stimulus pushes
// expected reads/IRQ levels, a monitor compares them each cycle.
module tb_timer_irq_source;
    import timer_irq_source_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    typedef struct {
        string       name;
        logic        is_irq;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    item_t it;
    logic [31:0] act;
    int n_chk  = 0;
    int n_fail = 0;

    timer_irq_source #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .We   (We),
        .DIn  (DIn),
        .DOut (DOut),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        We   = 1'b1;
        @(negedge clk);
        We   = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [1:0] a,
                      input logic [31:0] e);
        Addr = a;
        q.push_back('{name: nm, is_irq: 1'b0, exp: e});
    endtask

    task automatic irq(input string nm, input logic e);
        q.push_back('{name: nm, is_irq: 1'b1, exp: 32'(e)});
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (q.size() != 0) begin
                it  = q.pop_front();
                act = it.is_irq ? 32'(IRQ) : DOut;
                n_chk++;
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h",
                             it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        We    = 1'b0;
        Addr  = 2'd0;
        DIn   = 32'd0;
        repeat (3) tick();
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd("rst_dout", 2'(a), 32'd0);
            irq("rst_irq", 1'b0);
            tick();
        end

        // One-shot, PRESET=3
        wr(ADDR_PRESET, 32'd3);
        wr(ADDR_CTRL, 32'h9);
        tick();
        irq("os_e1", 1'b0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            rd("os_count", ADDR_COUNT, 32'(5 - k));
            irq("os_irq", k == 5);
        end
        tick();
        rd("os_ctrl_en_cleared", ADDR_CTRL, 32'h8);
        irq("os_hold", 1'b1);
        tick();
        irq("os_hold2", 1'b1);
        wr(ADDR_CTRL, 32'h8);
        irq("os_irq_cleared", 1'b0);
        rd("os_ctrl8", ADDR_CTRL, 32'h8);
        tick();

        // Periodic, PRESET=2: pulses at E+4, E+8, E+12
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'hB);
        for (int k = 1; k <= 13; k++) begin
            tick();
            irq("per_irq", (k == 4) || (k == 8) || (k == 12));
        end
        wr(ADDR_CTRL, 32'h0);
        tick();
        irq("per_off", 1'b0);

        // Masked one-shot, PRESET=1
        wr(ADDR_PRESET, 32'd1);
        wr(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            irq("mask_irq", 1'b0);
        end
        rd("mask_ctrl", ADDR_CTRL, 32'h0);
        wr(ADDR_CTRL, 32'h8);
        irq("mask_flag_clr", 1'b0);
        tick();
        irq("mask_flag_clr2", 1'b0);
        rd("mask_ctrl8", ADDR_CTRL, 32'h8);
        tick();

        // Disable mid-count, PRESET=10
        wr(ADDR_PRESET, 32'd10);
        wr(ADDR_CTRL, 32'h1);
        tick();
        for (int k = 2; k <= 4; k++) begin
            tick();
            rd("dis_count", ADDR_COUNT, 32'(12 - k));
        end
        tick();
        wr(ADDR_CTRL, 32'h0);
        rd("dis_frozen", ADDR_COUNT, 32'd6);
        for (int k = 0; k < 3; k++) begin
            tick();
            rd("dis_hold", ADDR_COUNT, 32'd6);
            irq("dis_irq", 1'b0);
        end
        tick();
        wr(ADDR_CTRL, 32'h1);
        tick();
        rd("reen_load", ADDR_COUNT, 32'd6);
        tick();
        rd("reen_reload", ADDR_COUNT, 32'd10);
        tick();
        wr(ADDR_CTRL, 32'h0);

        // PRESET=0 behaves as PRESET=1
        wr(ADDR_PRESET, 32'd0);
        wr(ADDR_CTRL, 32'h9);
        tick();
        tick();
        rd("p0_count", ADDR_COUNT, 32'd0);
        irq("p0_e2", 1'b0);
        tick();
        irq("p0_e3", 1'b1);
        wr(ADDR_CTRL, 32'h0);
        irq("p0_clr", 1'b0);

        // Ignored writes and CTRL masking
        wr(ADDR_PRESET, 32'h55);
        wr(ADDR_COUNT, 32'h1234);
        wr(2'd3, 32'hFFFF_FFFF);
        rd("ign_count", ADDR_COUNT, 32'd0);
        tick();
        rd("ign_preset", ADDR_PRESET, 32'h55);
        tick();
        rd("ign_ctrl", ADDR_CTRL, 32'h0);
        tick();
        rd("ign_addr3", 2'd3, 32'h0);
        tick();
        wr(ADDR_CTRL, 32'hFFFF_FF06);
        rd("ctrl_mask", ADDR_CTRL, 32'h6);
        irq("ctrl_mask_irq", 1'b0);
        tick();
        wr(ADDR_CTRL, 32'h0);

        // Reset asserted mid-count
        wr(ADDR_PRESET, 32'd8);
        wr(ADDR_CTRL, 32'h9);
        repeat (5) tick();
        rd("mid_count5", ADDR_COUNT, 32'd5);
        tick();
        reset = 1'b0;
        rd("mid_rst_count", ADDR_COUNT, 32'd0);
        irq("mid_rst_irq", 1'b0);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            irq("post_rst_irq", 1'b0);
        end
        rd("post_rst_count", ADDR_COUNT, 32'd0);
        tick();
        rd("post_rst_ctrl", ADDR_CTRL, 32'd0);
        tick();
        rd("post_rst_preset", ADDR_PRESET, 32'd0);

        repeat (3) tick();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
